// File: rtl/dp_arbiter.sv
// Four-requester round-robin arbiter feeding a shared fixed-latency 8-bit datapath.
// Optional macro ARB_PRIO0_EN gives requester 0 strict priority over requesters 1-3.
module dp_arbiter #(
  parameter int unsigned DP_LAT = 2  // legal range 1..8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic [7:0]  dp_i_data,
  input  logic [7:0]  dp_o_y,
  output logic        rsp_valid,
  output logic [1:0]  rsp_id,
  output logic [7:0]  rsp_data,
  output logic        busy
);

  // One extra stage so the tag lines up with the edge that samples dp_o_y.
  localparam int unsigned Stages = DP_LAT + 1;

  logic [1:0]        ptr_q;
  logic [3:0]        grant;
  logic [1:0]        grant_id;
  logic              grant_any;
  logic [1:0]        idx;
  logic [Stages-1:0] tag_v_q;
  logic [1:0]        tag_id_q [Stages];

  always_comb begin
    grant     = 4'b0000;
    grant_id  = 2'd0;
    grant_any = 1'b0;
    idx       = 2'd0;
`ifdef ARB_PRIO0_EN
    if (req_valid[0]) begin
      grant[0]  = 1'b1;
      grant_any = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        idx = ptr_q + 2'(i);
        if (!grant_any && idx != 2'd0 && req_valid[idx]) begin
          grant[idx] = 1'b1;
          grant_id   = idx;
          grant_any  = 1'b1;
        end
      end
    end
`else
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!grant_any && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        grant_any  = 1'b1;
      end
    end
`endif
  end

  assign req_ready = rst ? 4'b0000 : grant;
  assign busy      = |tag_v_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= 2'd0;
      dp_i_data <= 8'h00;
      tag_v_q   <= '0;
      for (int s = 0; s < Stages; s++) tag_id_q[s] <= 2'd0;
      rsp_valid <= 1'b0;
      rsp_id    <= 2'd0;
      rsp_data  <= 8'h00;
    end else begin
`ifdef ARB_PRIO0_EN
      // Strict-priority grants to requester 0 leave the rotation untouched.
      if (grant_any && grant_id != 2'd0) ptr_q <= grant_id + 2'd1;
`else
      if (grant_any) ptr_q <= grant_id + 2'd1;
`endif
      if (grant_any) dp_i_data <= req_data[8*grant_id +: 8];
      tag_v_q     <= {tag_v_q[Stages-2:0], grant_any};
      tag_id_q[0] <= grant_id;
      for (int s = 1; s < Stages; s++) tag_id_q[s] <= tag_id_q[s-1];
      rsp_valid <= tag_v_q[Stages-1];
      if (tag_v_q[Stages-1]) begin
        rsp_id   <= tag_id_q[Stages-1];
        rsp_data <= dp_o_y;
      end
    end
  end

endmodule

// File: tb/tb_dp_arbiter.sv
// Directed bench for dp_arbiter: arbitration model plus a response scoreboard queue.
// Datapath stand-in is a two-register delay of dp_i_data XORed with 8'h5A.
module tb_dp_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = 4'b0000;
  logic [31:0] req_data = 32'h0;
  logic [3:0]  req_ready;
  logic [7:0]  dp_i_data;
  logic [7:0]  dp_o_y;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        busy;

  logic [7:0] dp_r1, dp_r2;

  dp_arbiter #(.DP_LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .dp_i_data (dp_i_data),
    .dp_o_y    (dp_o_y),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_r1 <= 8'h00;
      dp_r2 <= 8'h00;
    end else begin
      dp_r1 <= dp_i_data;
      dp_r2 <= dp_r1;
    end
  end
  assign dp_o_y = dp_r2 ^ 8'h5A;

  typedef struct {
    int         due;
    logic [1:0] id;
    logic [7:0] data;
  } rsp_t;

  rsp_t       sb[$];
  int         total = 0;
  int         passes = 0;
  int         n = 0;
  logic [1:0] m_ptr = 2'd0;
  logic [7:0] m_dp = 8'h00;
  logic [1:0] m_id = 2'd0;
  logic [7:0] m_data = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] rr(input logic [3:0] v, input logic [1:0] p);
    logic [1:0] k;
`ifdef ARB_PRIO0_EN
    if (v[0]) return 4'b0001;
    for (int i = 0; i < 4; i++) begin
      k = p + 2'(i);
      if (k != 2'd0 && v[k]) return 4'b0001 << k;
    end
`else
    for (int i = 0; i < 4; i++) begin
      k = p + 2'(i);
      if (v[k]) return 4'b0001 << k;
    end
`endif
    return 4'b0000;
  endfunction

  // Called at a falling edge; drives one cycle of requests and checks everything after the edge.
  task automatic step(input logic [3:0] v, input logic [31:0] d,
                      input logic use_w, input logic [3:0] want);
    logic [3:0] g;
    logic [1:0] id;
    rsp_t       e;
    req_valid = v;
    req_data  = d;
    #1;
    g = rr(v, m_ptr);
    chk("req_ready", req_ready, g);
    if (use_w) chk("grant_order", req_ready, want);
    if (g != 4'b0000) begin
      id = 2'd0;
      for (int i = 0; i < 4; i++) if (g[i]) id = 2'(i);
      e.due  = n + 1 + 3;
      e.id   = id;
      e.data = d[8*id +: 8] ^ 8'h5A;
      sb.push_back(e);
      m_dp = d[8*id +: 8];
`ifdef ARB_PRIO0_EN
      if (id != 2'd0) m_ptr = id + 2'd1;
`else
      m_ptr = id + 2'd1;
`endif
    end
    @(posedge clk);
    n++;
    #1;
    chk("dp_i_data", dp_i_data, m_dp);
    if (sb.size() != 0 && sb[0].due == n) begin
      e = sb.pop_front();
      m_id   = e.id;
      m_data = e.data;
      chk("rsp_valid_hi", rsp_valid, 1'b1);
    end else begin
      chk("rsp_valid_lo", rsp_valid, 1'b0);
    end
    chk("rsp_id", rsp_id, m_id);
    chk("rsp_data", rsp_data, m_data);
    chk("busy", busy, sb.size() != 0);
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(4'b0000, 32'h0, 1'b0, 4'b0000);
  endtask

  // Asserted at a falling edge, held across one or more rising edges, released at a falling edge.
  task automatic pulse_reset(input int cycles);
    rst = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_dp_i_data", dp_i_data, 8'h00);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, 2'd0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_hold_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b0000;
    sb.delete();
    m_ptr = 2'd0;
    m_dp = 8'h00;
    m_id = 2'd0;
    m_data = 8'h00;
  endtask

  logic [3:0] order30 [6];
  logic [3:0] order31 [4];

  initial begin
    order30 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
`ifdef ARB_PRIO0_EN
    order31 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    order31 = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
`endif
    @(negedge clk);
    pulse_reset(2);

    // Single request on lane 2: A5 ^ 5A = FF.
    step(4'b0100, 32'h00A5_0000, 1'b1, 4'b0100);
    idle(5);

    pulse_reset(1);
    for (int i = 0; i < 6; i++) step(4'b1111, 32'h4433_2211 + 32'(i), 1'b1, order30[i]);
    idle(5);

    pulse_reset(1);
    for (int i = 0; i < 4; i++) step(4'b1001, 32'hD0C0_B0A0 + 32'(i), 1'b1, order31[i]);
    idle(5);

    // Reset with two transfers in flight: nothing from before reset may come out.
    step(4'b1111, 32'h1234_5678, 1'b0, 4'b0000);
    step(4'b1111, 32'h9ABC_DEF0, 1'b0, 4'b0000);
    pulse_reset(1);
    idle(10);
    step(4'b1111, 32'h0102_0304, 1'b1, 4'b0001);
    idle(5);

    step(4'b0001, 32'h0000_003C, 1'b0, 4'b0000);
    idle(20);
    chk("hold_3c", dp_i_data, 8'h3C);

    for (int i = 0; i < 40; i++) step(4'($urandom_range(0, 15)), $urandom, 1'b0, 4'b0000);
    idle(5);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
